// File: rtl/fp_addsub_seq_pkg.sv
// Shared types and constants for the sequential single-precision add/subtract.
package fp_addsub_pkg;

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned MANT_W = 24;

   localparam logic [EXP_W-1:0]  EXP_MAX  = 8'hFF;
   localparam logic [31:0]       POS_ZERO = 32'h0000_0000;
   localparam logic [FRAC_W-1:0] INF_FRAC = 23'h00_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXP,
      ST_ALIGN,
      ST_MANT,
      ST_MANT_FIX,
      ST_NORM,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

endpackage

// File: rtl/fp_addsub_seq_addsub.sv
// Shared 24-bit adder/subtractor; in subtract mode cout_c_o is the A>=B flag.
module adder_subtractor_24bit (
   input  logic [23:0] a_i,
   input  logic [23:0] b_i,
   input  logic        ctl_i,
   output logic [23:0] sum_c_o,
   output logic        cout_c_o
);

   logic [24:0] full_c;
   logic [23:0] b_eff_c;

   always_comb begin
      b_eff_c = ctl_i ? ~b_i : b_i;
      full_c  = 25'(a_i) + 25'(b_eff_c) + 25'(ctl_i);
   end

   assign sum_c_o  = full_c[23:0];
   assign cout_c_o = full_c[24];

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract built around one shared
// 24-bit adder/subtractor; truncating, subnormals flushed to zero.
module fp_addsub_seq
   import fp_addsub_pkg::*;
#(
   parameter logic [31:0] QNAN       = 32'h7FC0_0000,
   parameter int unsigned FTZ_INPUTS = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   state_e state_q, state_d;

   logic              sx_q, sx_d, sy_q, sy_d;
   logic [EXP_W-1:0]  ex_q, ex_d, ey_q, ey_d;
   logic [MANT_W-1:0] mx_q, mx_d, my_q, my_d;
   logic              sub_q, sub_d;
   logic [EXP_W-1:0]  diff_q, diff_d;
   logic              sign_q, sign_d;
   logic [EXP_W-1:0]  exp_q, exp_d;
   logic [MANT_W-1:0] mant_q, mant_d;
   logic              carry_q, carry_d;
   logic              early_q, early_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [31:0]       result_q, result_d;

   logic [MANT_W-1:0] u_a, u_b, u_sum;
   logic              u_ctl, u_cout;

   logic [EXP_W-1:0]  ea_c, eb_c;
   logic              za_c, zb_c, nan_c;
   fp32_t             pack_c;

   adder_subtractor_24bit u_addsub (
      .a_i      (u_a),
      .b_i      (u_b),
      .ctl_i    (u_ctl),
      .sum_c_o  (u_sum),
      .cout_c_o (u_cout)
   );

   // Next-state, datapath and shared-unit steering
   always_comb begin
      state_d  = state_q;
      sx_d     = sx_q;
      sy_d     = sy_q;
      ex_d     = ex_q;
      ey_d     = ey_q;
      mx_d     = mx_q;
      my_d     = my_q;
      sub_d    = sub_q;
      diff_d   = diff_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      mant_d   = mant_q;
      carry_d  = carry_q;
      early_d  = early_q;
      done_d   = 1'b0;
      result_d = result_q;
      u_a      = '0;
      u_b      = '0;
      u_ctl    = 1'b0;

      ea_c  = a[30:23];
      eb_c  = b[30:23];
      za_c  = (FTZ_INPUTS != 0) && (ea_c == '0);
      zb_c  = (FTZ_INPUTS != 0) && (eb_c == '0);
      nan_c = (ea_c == EXP_MAX) || (eb_c == EXP_MAX);

      pack_c.sign = sign_q;
      pack_c.exp  = exp_q;
      pack_c.frac = mant_q[FRAC_W-1:0];

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               sx_d    = a[31];
               ex_d    = ea_c;
               mx_d    = za_c ? '0 : {1'b1, a[22:0]};
               sy_d    = b[31] ^ op;
               ey_d    = eb_c;
               my_d    = zb_c ? '0 : {1'b1, b[22:0]};
               carry_d = 1'b0;
               early_d = nan_c || (za_c && zb_c);
               // Early exits preload the final fields and fall through EXP to DONE
               sign_d  = nan_c ? QNAN[31]    : 1'b0;
               exp_d   = nan_c ? QNAN[30:23] : '0;
               mant_d  = nan_c ? {1'b1, QNAN[22:0]} : '0;
               state_d = ST_EXP;
            end
         end

         ST_EXP: begin
            if (early_q) begin
               state_d = ST_DONE;
            end else begin
               u_a   = {16'b0, ex_q};
               u_b   = {16'b0, ey_q};
               u_ctl = 1'b1;
               sub_d = sx_q ^ sy_q;
               if (!u_cout) begin
                  sx_d   = sy_q;
                  ex_d   = ey_q;
                  mx_d   = my_q;
                  sy_d   = sx_q;
                  ey_d   = ex_q;
                  my_d   = mx_q;
                  diff_d = 8'(~u_sum[7:0] + 8'd1);
               end else begin
                  diff_d = u_sum[7:0];
               end
               state_d = ST_ALIGN;
            end
         end

         ST_ALIGN: begin
            my_d    = (diff_q >= 8'(MANT_W)) ? '0 : (my_q >> diff_q);
            state_d = ST_MANT;
         end

         ST_MANT: begin
            u_a     = mx_q;
            u_b     = my_q;
            u_ctl   = sub_q;
            mant_d  = u_sum;
            carry_d = u_cout & ~sub_q;
            sign_d  = sx_q;
            exp_d   = ex_q;
            state_d = (sub_q && !u_cout) ? ST_MANT_FIX : ST_NORM;
         end

         ST_MANT_FIX: begin
            u_a     = my_q;
            u_b     = mx_q;
            u_ctl   = 1'b1;
            mant_d  = u_sum;
            sign_d  = ~sx_q;
            state_d = ST_NORM;
         end

         ST_NORM: begin
            if (carry_q) begin
               u_a     = {16'b0, exp_q};
               u_b     = 24'd1;
               exp_d   = u_sum[7:0];
               mant_d  = (u_sum[7:0] == EXP_MAX) ? {1'b1, INF_FRAC}
                                                 : {1'b1, mant_q[MANT_W-1:1]};
               carry_d = 1'b0;
               state_d = ST_DONE;
            end else if (mant_q == '0) begin
               sign_d  = 1'b0;
               exp_d   = '0;
               state_d = ST_DONE;
            end else if (mant_q[MANT_W-1]) begin
               state_d = ST_DONE;
            end else begin
               u_a   = {16'b0, exp_q};
               u_b   = 24'd1;
               u_ctl = 1'b1;
               if (exp_q == 8'd1) begin
                  sign_d  = 1'b0;
                  exp_d   = '0;
                  mant_d  = '0;
                  state_d = ST_DONE;
               end else begin
                  exp_d  = u_sum[7:0];
                  mant_d = {mant_q[MANT_W-2:0], 1'b0};
               end
            end
         end

         ST_DONE: begin
            result_d = pack_c;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sx_q     <= 1'b0;
         sy_q     <= 1'b0;
         ex_q     <= '0;
         ey_q     <= '0;
         mx_q     <= '0;
         my_q     <= '0;
         sub_q    <= 1'b0;
         diff_q   <= '0;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         mant_q   <= '0;
         carry_q  <= 1'b0;
         early_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= POS_ZERO;
      end else begin
         state_q  <= state_d;
         sx_q     <= sx_d;
         sy_q     <= sy_d;
         ex_q     <= ex_d;
         ey_q     <= ey_d;
         mx_q     <= mx_d;
         my_q     <= my_d;
         sub_q    <= sub_d;
         diff_q   <= diff_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         mant_q   <= mant_d;
         carry_q  <= carry_d;
         early_q  <= early_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed-vector bench for fp_addsub_seq: results, latency and handshake.
module tb_fp_addsub_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done;
   logic [31:0] result;

   int nvec = 0;
   int nerr = 0;

   fp_addsub_seq dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   // Issue one operation; lat = edges after the accepting edge until done (-1 on timeout)
   task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic opv,
                        output logic [31:0] res, output int lat, output logic busy_ok);
      @(negedge clk);
      a = av; b = bv; op = opv; start = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      busy_ok = (busy === 1'b1);
      lat     = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      res = result;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", done); end
      nvec++; if (result !== 32'h0) begin nerr++; $display("FAIL reset_result got %h want 00000000", result); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_vec(input string name, input logic [31:0] av, input logic [31:0] bv,
                           input logic opv, input logic [31:0] exp_res, input int exp_lat);
      logic [31:0] res;
      int          lat;
      logic        bok;
      do_op(av, bv, opv, res, lat, bok);
      nvec++; if (res !== exp_res) begin nerr++; $display("FAIL %s result got %h want %h", name, res, exp_res); end
      nvec++; if (lat != exp_lat) begin nerr++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat); end
      nvec++; if (!bok) begin nerr++; $display("FAIL %s busy_after_start got 0 want 1", name); end
   endtask

   task automatic test_add_carry();
      test_vec("add_carry", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 5);
      @(posedge clk); #1;
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL done_pulse got %b want 0", done); end
      nvec++; if (result !== 32'h4000_0000) begin nerr++; $display("FAIL result_hold got %h want 40000000", result); end
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL idle_busy got %b want 0", busy); end
   endtask

   task automatic test_sub_paths();
      test_vec("sub_norm",   32'h3FC0_0000, 32'h3F80_0000, 1'b1, 32'h3F00_0000, 6);
      test_vec("sub_fix",    32'h3F80_0000, 32'h3FC0_0000, 1'b1, 32'hBF00_0000, 7);
      test_vec("cancel",     32'h4049_0FDB, 32'h4049_0FDB, 1'b1, 32'h0000_0000, 5);
      test_vec("add_unlike", 32'h3F80_0000, 32'hBFC0_0000, 1'b0, 32'hBF00_0000, 7);
   endtask

   task automatic test_align();
      test_vec("align_flush", 32'h3F80_0000, 32'h3080_0000, 1'b0, 32'h3F80_0000, 5);
      test_vec("align_swap",  32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 5);
   endtask

   task automatic test_specials();
      test_vec("inf_qnan",  32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 2);
      test_vec("zero_zero", 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 2);
      test_vec("overflow",  32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 5);
      test_vec("zero_one",  32'h0000_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 5);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      a = 32'h3FC0_0000; b = 32'h3F80_0000; op = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL midrst_busy got %b want 0", busy); end
      rst = 1'b0;
      begin
         logic seen = 1'b0;
         for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1'b1;
         end
         nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL midrst_done got %b want 0", seen); end
      end
      test_vec("after_rst", 32'h3FC0_0000, 32'h3F80_0000, 1'b1, 32'h3F00_0000, 6);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      a = 32'h7F80_0000; b = 32'h3F80_0000; op = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL b2b_busy0 got %b want 1", busy); end
      @(posedge clk); #1;
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL b2b_early_done got %b want 0", done); end
      @(posedge clk); #1;
      nvec++; if (done !== 1'b1 || result !== 32'h7FC0_0000) begin
         nerr++; $display("FAIL b2b_first got done=%b result=%h want done=1 result=7fc00000", done, result);
      end
      a = 32'h3F80_0000; b = 32'h3F80_0000;
      @(posedge clk); #1;
      start = 1'b0;
      nvec++; if (busy !== 1'b1 || done !== 1'b0) begin
         nerr++; $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", busy, done);
      end
      begin
         logic early = 1'b0;
         for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) early = 1'b1;
         end
         nvec++; if (early !== 1'b0) begin nerr++; $display("FAIL b2b_gap got %b want 0", early); end
      end
      @(posedge clk); #1;
      nvec++; if (done !== 1'b1 || result !== 32'h4000_0000) begin
         nerr++; $display("FAIL b2b_second got done=%b result=%h want done=1 result=40000000", done, result);
      end
   endtask

   initial begin
      test_reset();
      test_add_carry();
      test_sub_paths();
      test_align();
      test_specials();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
